// File: rtl/instr_fetch_reg.sv
// Instruction fetch stage: issues one aligned word read per fetch_start, captures it
// into the instruction register, and decodes the MIPS-style fields from that register.
module instr_fetch_reg #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic [31:0] pc_in,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        ir_valid,
    output logic        fault,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr,
    output logic        dbg_state
);

    // Memory handshake: mem_rd stays high for every READ cycle; the word is taken on
    // the first rising edge that samples mem_ready=1, and mem_rd drops on that edge.
    // mem_ready outside READ carries no meaning and is ignored.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_start) begin
                    valid_d = 1'b0;
                    if (pc_in[1:0] == 2'b00) begin
                        state_d = S_READ;
                        addr_d  = pc_in;
                        cnt_d   = '0;
                        fault_d = 1'b0;
                    end else begin
                        // Misaligned request is refused without touching memory.
                        fault_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                // Data arriving on the timeout edge still counts as a good fetch.
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_rd    = (state_q == S_READ);
    assign busy      = (state_q == S_READ);
    assign ir_valid  = valid_q;
    assign fault     = fault_q;
    assign dbg_state = state_q;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign imm16  = ir_q[15:0];
    assign jaddr  = ir_q[25:0];

endmodule

// File: doc/instr_fetch_reg.md
INSTR_FETCH_REG -- requirements
Module: instr_fetch_reg

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum READ cycles allowed without mem_ready before a fault is declared (1..255).
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: fetch_start  input  1  control-unit request to fetch the instruction at pc_in.
REQ-005 Port: pc_in  input  32  byte address of the instruction.
REQ-006 Port: mem_addr  output  32  registered fetch address driven to memory.
REQ-007 Port: mem_rd  output  1  memory read strobe.
REQ-008 Port: mem_ready  input  1  memory data-valid acknowledge.
REQ-009 Port: mem_rdata  input  32  memory read data.
REQ-010 Port: busy  output  1  high while in READ.
REQ-011 Port: ir_valid  output  1  instruction register holds a freshly fetched word.
REQ-012 Port: fault  output  1  last fetch failed, due to misalignment or timeout.
REQ-013 Ports: opcode 6 [31:26]; rs 5 [25:21]; rt 5 [20:16]; rd 5 [15:11]; shamt 5 [10:6]; funct 6 [5:0]; imm16 16 [15:0], feeding the 16-to-32 sign extender; jaddr 26 [25:0]; all are outputs decoded from IR.

Function
REQ-014 The block SHALL hold a 32-bit instruction register IR, a 2-state FSM (IDLE, READ), and an 8-bit wait counter.
REQ-015 The decoded field outputs SHALL be combinational slices of IR only and SHALL never be driven directly from mem_rdata.
REQ-016 IDLE, fetch_start=1, pc_in[1:0]=00: the block SHALL go to READ, latch mem_addr=pc_in, clear the counter, clear ir_valid and clear fault.
REQ-017 IDLE, fetch_start=1, pc_in[1:0]!=00: the block SHALL stay in IDLE, set fault=1, clear ir_valid, leave IR and mem_addr unchanged, and never assert mem_rd.
REQ-018 In READ the block SHALL hold mem_rd=1 and busy=1, and mem_addr SHALL stay stable.
REQ-019 READ, mem_ready=1 sampled: the block SHALL set IR=mem_rdata and ir_valid=1, and go to IDLE, so mem_rd drops on that edge.
REQ-020 Minimum latency: fetch_start high at edge N and mem_ready high at edge N+1 SHALL give ir_valid=1 and the new fields after edge N+1.
REQ-021 READ, mem_ready=0: the counter SHALL increment; a counter value of TIMEOUT-1 sampled with mem_ready=0 SHALL set fault=1, go to IDLE, and leave IR and ir_valid=0 unchanged.
REQ-022 If mem_ready=1 arrives on the same edge as the timeout condition, mem_ready SHALL win: the block captures the data and sets no fault.
REQ-023 fetch_start while in READ SHALL be ignored, with no restart and no address change.
REQ-024 ir_valid and fault SHALL be level signals, held until the next accepted fetch_start or reset, and never both high.
REQ-025 mem_ready while in IDLE SHALL be ignored, leaving IR unchanged.
REQ-026 IR SHALL change only on a READ-state capture or on reset.

Reset
REQ-027 On any clk edge with reset=1, the block SHALL set state=IDLE, IR=0, mem_addr=0, counter=0, mem_rd=0, busy=0, ir_valid=0 and fault=0, so all decoded fields read 0.
REQ-028 Reset SHALL take priority over fetch_start and mem_ready.
REQ-029 Reset during READ SHALL abort the fetch with mem_rd=0 after that edge, and a later mem_ready SHALL be ignored.

Verification
REQ-030 The bench SHALL cover the zero-wait fetch: reset, then fetch_start with pc_in=0x00000040, then mem_ready=1 the next cycle with mem_rdata=0x8D09FFFC. Required: mem_rd high for exactly 1 cycle, mem_addr=0x40, ir_valid=1, opcode=0x23, rs=8, rt=9, imm16=0xFFFC, fault=0.
REQ-031 The bench SHALL cover the wait-state fetch: mem_ready held low for 5 cycles, then high with 0x012A4020. Required: busy high for 6 cycles, rd=8, funct=0x20, shamt=0, ir_valid=1.
REQ-032 The bench SHALL cover the timeout: TIMEOUT=4 and mem_ready never asserted. Required: mem_rd high for 4 cycles, then fault=1, ir_valid=0, and IR keeps its previous value.
REQ-033 The bench SHALL cover the misaligned fetch: fetch_start with pc_in=0x00000042. Required: fault=1 on the next cycle, mem_rd never asserted, IR unchanged.
REQ-034 The bench SHALL cover reset mid-READ: reset asserted on the 2nd READ cycle, then mem_ready=1 with 0xFFFFFFFF. Required: all outputs 0, IR stays 0.
REQ-035 The bench SHALL cover simultaneous events: mem_ready and timeout on the same edge, and fetch_start asserted during READ. Required: the data is captured with fault=0, and mem_addr is unchanged by the second fetch_start.
